// File: rtl/frogger_game_ctrl.sv
`default_nettype none
// frogger_game_ctrl: Frogger phase sequencer. Arbitrates switch presses into single moves,
// keeps lives/level/score, and times the death and level-up pauses in VGA frames.
module frogger_game_ctrl #(
  parameter int LIVES        = 3,
  parameter int MAX_LEVEL    = 9,
  parameter int DEATH_FRAMES = 60,
  parameter int LEVEL_FRAMES = 30
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_VSync,
  input  logic       i_Up_Mvt,
  input  logic       i_Down_Mvt,
  input  logic       i_Left_Mvt,
  input  logic       i_Right_Mvt,
  input  logic       i_Collision,
  input  logic       i_Goal,
  output logic [2:0] o_State,
  output logic       o_Move_Valid,
  output logic [1:0] o_Move_Dir,
  output logic       o_Frog_Respawn,
  output logic       o_Freeze,
  output logic [1:0] o_Lives,
  output logic [3:0] o_Level,
  output logic [6:0] o_Score
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAY      = 3'd1,
    DYING     = 3'd2,
    LEVEL_UP  = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [3:0] LEVEL_TOP  = 4'(MAX_LEVEL);
  localparam logic [7:0] DEATH_END  = 8'(DEATH_FRAMES);
  localparam logic [7:0] LEVEL_END  = 8'(LEVEL_FRAMES);
  localparam logic [6:0] SCORE_TOP  = 7'd99;

  state_t     state, state_nxt;
  logic [3:0] sw, sw_prev, rise;
  logic       vsync_prev, frame_tick, start_evt;
  logic [7:0] frame_cnt, frame_cnt_nxt, frame_cnt_inc;
  logic [1:0] lives, lives_nxt;
  logic [3:0] level, level_nxt;
  logic [6:0] score, score_nxt;
  logic       move_valid_nxt, respawn_nxt;
  logic [1:0] move_dir_nxt;

  // Bit index equals the direction code, so lower index means higher priority.
  assign sw            = {i_Right_Mvt, i_Left_Mvt, i_Down_Mvt, i_Up_Mvt};
  assign rise          = sw & ~sw_prev;
  assign start_evt     = (&sw) & ~(&sw_prev);
  assign frame_tick    = vsync_prev & ~i_VSync;
  assign frame_cnt_inc = frame_cnt + 8'd1;

  always_comb begin
    state_nxt      = state;
    lives_nxt      = lives;
    level_nxt      = level;
    score_nxt      = score;
    frame_cnt_nxt  = frame_cnt;
    move_valid_nxt = 1'b0;
    move_dir_nxt   = 2'd0;
    respawn_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (start_evt) begin
          state_nxt   = PLAY;
          respawn_nxt = 1'b1;
        end
      end
      PLAY: begin
        if (i_Collision) begin
          state_nxt     = DYING;
          frame_cnt_nxt = 8'd0;
          if (lives != 2'd0) lives_nxt = lives - 2'd1;
        end else if (i_Goal) begin
          state_nxt     = LEVEL_UP;
          frame_cnt_nxt = 8'd0;
          if (score < SCORE_TOP) score_nxt = score + 7'd1;
          if (level < LEVEL_TOP) level_nxt = level + 4'd1;
        end else if (|rise) begin
          move_valid_nxt = 1'b1;
          if (rise[0])      move_dir_nxt = 2'd0;
          else if (rise[1]) move_dir_nxt = 2'd1;
          else if (rise[2]) move_dir_nxt = 2'd2;
          else              move_dir_nxt = 2'd3;
        end
      end
      DYING: begin
        if (frame_tick) begin
          frame_cnt_nxt = frame_cnt_inc;
          if (frame_cnt_inc == DEATH_END) begin
            if (lives == 2'd0) begin
              state_nxt = GAME_OVER;
            end else begin
              state_nxt   = PLAY;
              respawn_nxt = 1'b1;
            end
          end
        end
      end
      LEVEL_UP: begin
        if (frame_tick) begin
          frame_cnt_nxt = frame_cnt_inc;
          if (frame_cnt_inc == LEVEL_END) begin
            state_nxt   = PLAY;
            respawn_nxt = 1'b1;
          end
        end
      end
      GAME_OVER: begin
        if (start_evt) begin
          state_nxt   = PLAY;
          respawn_nxt = 1'b1;
          lives_nxt   = LIVES_INIT;
          level_nxt   = 4'd1;
          score_nxt   = 7'd0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state          <= IDLE;
      lives          <= LIVES_INIT;
      level          <= 4'd1;
      score          <= 7'd0;
      frame_cnt      <= 8'd0;
      sw_prev        <= 4'd0;
      vsync_prev     <= 1'b1;
      o_Move_Valid   <= 1'b0;
      o_Move_Dir     <= 2'd0;
      o_Frog_Respawn <= 1'b0;
      o_Freeze       <= 1'b1;
    end else begin
      state          <= state_nxt;
      lives          <= lives_nxt;
      level          <= level_nxt;
      score          <= score_nxt;
      frame_cnt      <= frame_cnt_nxt;
      sw_prev        <= sw;
      vsync_prev     <= i_VSync;
      o_Move_Valid   <= move_valid_nxt;
      o_Move_Dir     <= move_dir_nxt;
      o_Frog_Respawn <= respawn_nxt;
      o_Freeze       <= (state_nxt != PLAY);
    end
  end

  assign o_State = state;
  assign o_Lives = lives;
  assign o_Level = level;
  assign o_Score = score;

endmodule
`default_nettype wire

// File: tb/tb_frogger_game_ctrl.sv
`default_nettype none
// tb_frogger_game_ctrl: game-rule reference model feeding an event scoreboard,
// plus directed scenarios for start, arbitration, death, game over, saturation and reset.
module tb_frogger_game_ctrl;
  localparam int LIVES        = 3;
  localparam int MAX_LEVEL    = 9;
  localparam int DEATH_FRAMES = 60;
  localparam int LEVEL_FRAMES = 30;
  localparam int VS_PERIOD    = 6;

  logic clk = 1'b0, rst = 1'b1, vsync = 1'b1;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, coll = 1'b0, goal = 1'b0;
  logic [2:0] state;
  logic       mv, resp, frz;
  logic [1:0] dir, lives;
  logic [3:0] level;
  logic [6:0] score;

  int vectors = 0, miscompares = 0, cyc = 0;

  frogger_game_ctrl #(
    .LIVES(LIVES), .MAX_LEVEL(MAX_LEVEL), .DEATH_FRAMES(DEATH_FRAMES), .LEVEL_FRAMES(LEVEL_FRAMES)
  ) dut (
    .i_Clk(clk), .i_Reset(rst), .i_VSync(vsync),
    .i_Up_Mvt(up), .i_Down_Mvt(down), .i_Left_Mvt(left), .i_Right_Mvt(right),
    .i_Collision(coll), .i_Goal(goal),
    .o_State(state), .o_Move_Valid(mv), .o_Move_Dir(dir), .o_Frog_Respawn(resp),
    .o_Freeze(frz), .o_Lives(lives), .o_Level(level), .o_Score(score)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         cyc;
    logic [2:0] st;
    logic       mv;
    logic [1:0] dir;
    logic       resp;
    logic       frz;
    logic [1:0] lives;
    logic [3:0] lvl;
    logic [6:0] score;
  } ev_t;

  ev_t exp_q[$];

  function automatic ev_t strip(ev_t x);
    x.cyc = 0;
    return x;
  endfunction

  function automatic string fmt(ev_t x);
    return $sformatf("cyc=%0d st=%0d mv=%0d dir=%0d resp=%0d frz=%0d lives=%0d lvl=%0d score=%0d",
                     x.cyc, x.st, x.mv, x.dir, x.resp, x.frz, x.lives, x.lvl, x.score);
  endfunction

  // Free-running vertical sync: low for one cycle in every VS_PERIOD cycles.
  int vcnt = 0;
  always begin
    @(posedge clk); #1;
    vcnt  = (vcnt + 1) % VS_PERIOD;
    vsync = (vcnt != 0);
  end

  // Reference model: game rules applied to the inputs sampled at each clock edge.
  int   m_phase = 0, m_lives = LIVES, m_level = 1, m_score = 0, m_frames = 0;
  logic [3:0] m_prev = 4'd0;
  logic m_vs_prev = 1'b1;
  ev_t  m_last;

  initial begin
    m_last = '0;
    m_last.frz = 1'b1; m_last.lives = 2'(LIVES); m_last.lvl = 4'd1;
  end

  always @(posedge clk) begin
    logic [3:0] swv, r;
    bit   start, tick, mvv, rsp;
    int   d, limit;
    ev_t  e;
    cyc++;
    swv = {right, left, down, up};
    mvv = 0; rsp = 0; d = 0;
    if (rst) begin
      m_phase = 0; m_lives = LIVES; m_level = 1; m_score = 0; m_frames = 0;
      m_prev = 4'd0; m_vs_prev = 1'b1;
    end else begin
      r     = swv & ~m_prev;
      start = (swv == 4'hF) && (m_prev != 4'hF);
      tick  = m_vs_prev && !vsync;
      case (m_phase)
        0: if (start) begin m_phase = 1; rsp = 1; end
        1: begin
          if (coll) begin
            if (m_lives > 0) m_lives--;
            m_phase = 2; m_frames = 0;
          end else if (goal) begin
            m_score = (m_score >= 99) ? 99 : m_score + 1;
            m_level = (m_level >= MAX_LEVEL) ? MAX_LEVEL : m_level + 1;
            m_phase = 3; m_frames = 0;
          end else begin
            for (int i = 0; i < 4; i++)
              if (!mvv && r[i]) begin mvv = 1; d = i; end
          end
        end
        2, 3: if (tick) begin
          m_frames++;
          limit = (m_phase == 2) ? DEATH_FRAMES : LEVEL_FRAMES;
          if (m_frames == limit) begin
            if (m_phase == 2 && m_lives == 0) m_phase = 4;
            else begin m_phase = 1; rsp = 1; end
          end
        end
        default: if (start) begin
          m_phase = 1; rsp = 1; m_lives = LIVES; m_level = 1; m_score = 0;
        end
      endcase
      m_prev = swv; m_vs_prev = vsync;
    end
    e.cyc = cyc; e.st = 3'(m_phase); e.mv = mvv; e.dir = 2'(d); e.resp = rsp;
    e.frz = (m_phase != 1); e.lives = 2'(m_lives); e.lvl = 4'(m_level); e.score = 7'(m_score);
    if (mvv || rsp || strip(e) != m_last) exp_q.push_back(e);
    m_last = strip(e);
  end

  // Monitor: any pulse or visible change on the DUT outputs is an event to match.
  ev_t d_last;
  bit  mon_on = 0;
  always @(negedge clk) begin
    ev_t s, x;
    s.cyc = cyc; s.st = state; s.mv = mv; s.dir = mv ? dir : 2'd0; s.resp = resp;
    s.frz = frz; s.lives = lives; s.lvl = level; s.score = score;
    if (!mon_on) begin
      if (cyc >= 2) begin mon_on = 1; d_last = strip(s); end
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        x = exp_q.pop_front();
        vectors++; miscompares++;
        $display("FAIL missed_event: actual none, required %s", fmt(x));
      end
      if (s.mv || s.resp || strip(s) != d_last) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event: actual %s, required none", fmt(s));
        end else begin
          x = exp_q.pop_front();
          if (x !== s) begin
            miscompares++;
            $display("FAIL event: actual %s, required %s", fmt(s), fmt(x));
          end
        end
      end
      d_last = strip(s);
    end
  end

  task automatic chk(string name, int act, int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: actual %0d, required %0d", name, act, expv);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sw(logic [3:0] m);
    {right, left, down, up} = m;
  endtask

  task automatic wait_state(int s, int budget, string name);
    int k = 0;
    while (int'(state) != s && k < budget) begin step(1); k++; end
    chk(name, int'(state), s);
  endtask

  task automatic start_game();
    set_sw(4'hF); step(1); set_sw(4'h0); step(1);
  endtask

  task automatic do_goal();
    goal = 1'b1; step(1); goal = 1'b0;
    wait_state(1, LEVEL_FRAMES * VS_PERIOD + 20, "levelup_exit");
  endtask

  initial begin
    int pulses;
    rst = 1'b1; step(4);
    chk("reset_state", state, 0); chk("reset_freeze", frz, 1); chk("reset_lives", lives, LIVES);
    chk("reset_level", level, 1); chk("reset_score", score, 0); chk("reset_move", mv, 0);
    rst = 1'b0; step(5);

    set_sw(4'hF); step(1);
    chk("start_state", state, 1); chk("start_respawn", resp, 1); chk("start_move", mv, 0);
    chk("start_freeze", frz, 0);
    set_sw(4'h0); step(1);
    chk("respawn_one_cycle", resp, 0);

    set_sw(4'b1100); step(1);
    chk("arb_valid", mv, 1); chk("arb_dir", dir, 2);
    set_sw(4'b0100); pulses = 0;
    repeat (1000) begin step(1); pulses += int'(mv); end
    chk("hold_no_repeat", pulses, 0);
    set_sw(4'h0); step(2);

    coll = 1'b1; goal = 1'b1; step(1); coll = 1'b0; goal = 1'b0;
    chk("cg_state", state, 2); chk("cg_lives", lives, 2); chk("cg_score", score, 0);
    chk("cg_freeze", frz, 1);
    wait_state(1, DEATH_FRAMES * VS_PERIOD + 20, "death_exit");
    chk("death_respawn", resp, 1);

    coll = 1'b1; step(1); coll = 1'b0;
    wait_state(1, DEATH_FRAMES * VS_PERIOD + 20, "death2_exit");
    coll = 1'b1; step(1); coll = 1'b0;
    chk("last_life_lives", lives, 0);
    wait_state(4, DEATH_FRAMES * VS_PERIOD + 20, "game_over");
    chk("game_over_lives", lives, 0);
    set_sw(4'hF); step(1); set_sw(4'h0);
    chk("restart_state", state, 1); chk("restart_lives", lives, LIVES);
    chk("restart_score", score, 0); chk("restart_level", level, 1); chk("restart_respawn", resp, 1);
    step(1);

    repeat (4000) begin
      if ($urandom_range(0, 99) < 20) set_sw(4'($urandom));
      coll = ($urandom_range(0, 199) == 0);
      goal = ($urandom_range(0, 149) == 0);
      step(1);
    end
    coll = 1'b0; goal = 1'b0; set_sw(4'h0); step(2);

    rst = 1'b1; step(2); rst = 1'b0; step(2);
    start_game();
    repeat (12) do_goal();
    chk("sat_level", level, MAX_LEVEL); chk("sat_score12", score, 12);
    repeat (87) do_goal();
    chk("score_99", score, 99);
    do_goal();
    chk("score_hold_99", score, 99); chk("level_hold", level, MAX_LEVEL);

    coll = 1'b1; step(1); coll = 1'b0;
    step(20 * VS_PERIOD);
    chk("mid_dying_state", state, 2);
    rst = 1'b1; step(1);
    chk("mid_rst_state", state, 0); chk("mid_rst_freeze", frz, 1);
    chk("mid_rst_lives", lives, LIVES); chk("mid_rst_respawn", resp, 0);
    rst = 1'b0; step(5);

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_events: actual %0d left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/frogger_game_ctrl.md
# frogger_game_ctrl

Game-phase controller for Frogger. It sits between the four debounced switch outputs and `frogger_game`, and sequences play through idle, play, death, level-up and game-over phases. It turns switch presses into single arbitrated move commands and keeps lives, level and score. It derives a frame tick from the VGA vertical sync so that phase durations are counted in video frames.

## Interface
Parameters:
- `LIVES`, 3: starting lives, 1..3.
- `MAX_LEVEL`, 9: level saturation value, 1..15.
- `DEATH_FRAMES`, 60: frames spent in DYING, 1..255.
- `LEVEL_FRAMES`, 30: frames spent in LEVEL_UP, 1..255.

Ports:
- `i_Clk`  in  1  system clock; the only clock.
- `i_Reset`  in  1  reset, synchronous, active-high.
- `i_VSync`  in  1  VGA vertical sync, active-low.
- `i_Up_Mvt`, `i_Down_Mvt`, `i_Left_Mvt`, `i_Right_Mvt`  in  1 each  debounced switches, high while pressed.
- `i_Collision`  in  1  frog overlaps a hazard this cycle.
- `i_Goal`  in  1  frog occupies the goal row this cycle.
- `o_State`  out  3  0=IDLE, 1=PLAY, 2=DYING, 3=LEVEL_UP, 4=GAME_OVER.
- `o_Move_Valid`  out  1  one-cycle move command.
- `o_Move_Dir`  out  2  direction: 0=up, 1=down, 2=left, 3=right; valid only with `o_Move_Valid`.
- `o_Frog_Respawn`  out  1  one-cycle pulse that returns the frog to its spawn tile.
- `o_Freeze`  out  1  high means the datapath halts all object motion.
- `o_Lives`  out  2  remaining lives.
- `o_Level`  out  4  current level, 1..`MAX_LEVEL`.
- `o_Score`  out  7  binary score, 0..99, feeding the two 7-segment digits.

## Operation
- **Edge detection:** each switch has a registered previous value. A rising edge is current=1 and previous=0.
- **Start event:** rising edge of the AND of all four switches.
- **Frame tick:** internal one-cycle pulse when `i_VSync` was 1 last cycle and is 0 now. The previous-value register resets to 1.
- **IDLE:**
  - `o_Freeze`=1 and moves are suppressed.
  - Start event → PLAY, with `o_Frog_Respawn`=1 on the same cycle.
- **PLAY:**
  - `o_Freeze`=0.
  - Switch rising edges produce `o_Move_Valid`. When several edges arrive in the same cycle, priority is up > down > left > right and the losers are discarded, not queued.
  - `i_Collision`=1 → DYING; `o_Lives` decrements on the transition. Collision wins over a simultaneous `i_Goal`.
  - `i_Goal`=1 with no collision → LEVEL_UP.
    - `o_Score` += 1, saturating at 99.
    - `o_Level` += 1, saturating at `MAX_LEVEL`.
  - A move edge on the same cycle as a collision or goal is dropped.
- **DYING:**
  - `o_Freeze`=1 and moves are suppressed.
  - An 8-bit frame counter is cleared on entry and counts frame ticks.
  - On the frame tick that makes the count reach `DEATH_FRAMES`:
    - lives = 0 → GAME_OVER.
    - otherwise → PLAY with `o_Frog_Respawn`=1.
- **LEVEL_UP:**
  - Same counting as DYING, using `LEVEL_FRAMES`.
  - Exits to PLAY with `o_Frog_Respawn`=1.
- **GAME_OVER:**
  - `o_Freeze`=1.
  - Score, level and lives hold for display.
  - Start event → PLAY with `o_Frog_Respawn`=1; lives=`LIVES`, level=1, score=0 on the same edge.
- **Level-ups:** the start combination held during PLAY yields only an up move. No restart from PLAY.
- **Ignored inputs:** `i_Collision` and `i_Goal` are ignored outside PLAY.
- **Lives counter:** never underflows. Decrement happens only on entering DYING, and lives ≥ 1 is guaranteed in PLAY.

## Timing
- **Reset values** (on any clock edge with `i_Reset`=1, including mid-DYING or mid-LEVEL_UP):
  - `o_State`=IDLE.
  - `o_Move_Valid`=0, `o_Move_Dir`=0, `o_Frog_Respawn`=0.
  - `o_Freeze`=1.
  - `o_Lives`=`LIVES`, `o_Level`=1, `o_Score`=0.
  - Frame counter and edge registers cleared; VSync previous-value register = 1.
- **Registered outputs:** all outputs are registered.
- **Move latency:** switch rising edge sampled at edge N → `o_Move_Valid` high at N+1 for exactly one cycle.
- **Collision/goal latency:** `i_Collision` or `i_Goal` sampled at edge N → new state, lives, score and level visible at N+1. `o_Freeze` goes high at N+1.
- **Respawn pulse:** `o_Frog_Respawn` is high for exactly the one cycle in which `o_State` first reads PLAY after a transition.
- **Phase duration:** DYING lasts from entry until the `DEATH_FRAMES`-th frame tick after entry. A frame tick on the entry cycle itself is not counted.
- **Holding switches:** a switch held high produces no repeat moves; a new press requires a release first.

## Test plan
- **Reset and start:** reset, then all four switches rise together at cycle 10 → cycle 11 shows state=1, respawn=1 for one cycle, lives=3, level=1, score=0, no move pulse.
- **Move arbitration:** in PLAY, left and right rise on the same cycle → exactly one `o_Move_Valid` with dir=2. Hold left for 1000 cycles → no further pulses.
- **Collision beats goal:** in PLAY, `i_Collision` and `i_Goal` both asserted on the same cycle → state=2, lives 3→2, score unchanged. After 60 VSync falling edges → state=1 with respawn pulse.
- **Game over and restart:** three collisions → after the third DYING completes, state=4 with lives=0. Start combination → state=1, lives=3, score=0, level=1.
- **Saturation:** 12 goals with `MAX_LEVEL`=9 → level=9, score=12. Preload score 99, then one goal → score remains 99.
- **Reset mid-operation:** assert `i_Reset` mid-DYING after 20 frames → next cycle state=0, freeze=1, lives=3. No respawn pulse.
